// File: rtl/onehot_to_bin_stream.sv
// ----------------------------------------------------------------------------
// onehot_to_bin_stream
//
// Purpose:
//   Streaming one-hot to binary encoder with a single registered output
//   stage and valid/ready handshakes on both sides. It flags words with no
//   bit set (zero) or more than one bit set (multi). It also keeps a
//   saturating count of such illegal words.
//
// Parameters:
//   ONEHOT_WIDTH - number of one-hot input bits (>= 2)
//   BIN_WIDTH    - width of the encoded index (>= 1)
//   PRIO_MODE    - 0: OR together the indices of all set bits
//                  1: report the index of the lowest set bit
//   CNT_WIDTH    - width of the saturating error counter
//
// Ports:
//   clk_i      - clock, all state updates on the rising edge
//   rst_ni     - asynchronous active-low reset
//   valid_i    - input word valid
//   ready_o    - block can accept an input word this cycle
//   onehot_i   - one-hot word to encode
//   valid_o    - output result valid
//   ready_i    - downstream accepts the result
//   bin_o      - encoded index
//   zero_o     - accepted word had no bit set
//   multi_o    - accepted word had more than one bit set
//   clr_i      - synchronous clear of err_cnt_o (wins over an increment)
//   err_cnt_o  - saturating count of accepted illegal words
// ----------------------------------------------------------------------------
module onehot_to_bin_stream #(
    parameter int ONEHOT_WIDTH = 16,
    parameter int BIN_WIDTH    = $clog2(ONEHOT_WIDTH),
    parameter int PRIO_MODE    = 0,
    parameter int CNT_WIDTH    = 8
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    valid_i,
    output logic                    ready_o,
    input  logic [ONEHOT_WIDTH-1:0] onehot_i,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic [BIN_WIDTH-1:0]    bin_o,
    output logic                    zero_o,
    output logic                    multi_o,
    input  logic                    clr_i,
    output logic [CNT_WIDTH-1:0]    err_cnt_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic                 valid_q;
    logic [BIN_WIDTH-1:0] bin_q;
    logic                 zero_q;
    logic                 multi_q;
    logic [CNT_WIDTH-1:0] err_cnt_q;

    logic [BIN_WIDTH-1:0] or_enc;
    logic [BIN_WIDTH-1:0] prio_enc;
    logic [BIN_WIDTH-1:0] bin_d;
    logic                 found;
    logic                 multi_d;
    logic                 zero_d;
    logic                 in_hs;
    logic                 illegal;

    // Walk the input word once and build both encodings side by side.
    // The OR encoding merges the indices of every set bit. The priority
    // encoding latches the first (lowest) set bit it sees. A set bit that
    // arrives after one was already found marks the word as multi. Indices
    // wider than BIN_WIDTH are truncated by the cast, so only their low
    // bits contribute.
    always_comb begin
        or_enc   = '0;
        prio_enc = '0;
        found    = 1'b0;
        multi_d  = 1'b0;
        for (int i = 0; i < ONEHOT_WIDTH; i++) begin
            if (onehot_i[i]) begin
                or_enc = or_enc | BIN_WIDTH'(i);
                if (found) begin
                    multi_d = 1'b1;
                end else begin
                    prio_enc = BIN_WIDTH'(i);
                    found    = 1'b1;
                end
            end
        end
        zero_d = ~found;
        bin_d  = (PRIO_MODE != 0) ? prio_enc : or_enc;
    end

    // The single output stage can take a new word whenever it is empty or
    // is being drained this same cycle. That keeps full throughput, and
    // back-pressure passes straight through from ready_i.
    assign ready_o = ~valid_q | ready_i;
    assign in_hs   = valid_i & ready_o;
    assign illegal = zero_d | multi_d;

    // Output stage register. A new word always overwrites the stage, which
    // covers the simultaneous in/out handshake case. Otherwise a drain
    // empties it. While the stage is stalled the data stays untouched.
    // Reset drops any pending result.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_q <= 1'b0;
            bin_q   <= '0;
            zero_q  <= 1'b0;
            multi_q <= 1'b0;
        end else if (in_hs) begin
            valid_q <= 1'b1;
            bin_q   <= bin_d;
            zero_q  <= zero_d;
            multi_q <= multi_d;
        end else if (ready_i) begin
            valid_q <= 1'b0;
        end
    end

    // Error counter. A clear takes priority over everything. Otherwise each
    // accepted illegal word bumps the count until it pins at all-ones.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            err_cnt_q <= '0;
        end else if (clr_i) begin
            err_cnt_q <= '0;
        end else if (in_hs && illegal && (err_cnt_q != CNT_MAX)) begin
            err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

    assign valid_o   = valid_q;
    assign bin_o     = bin_q;
    assign zero_o    = zero_q;
    assign multi_o   = multi_q;
    assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_onehot_to_bin_stream.sv
// ----------------------------------------------------------------------------
// tb_onehot_to_bin_stream
//
// Directed bench for onehot_to_bin_stream. Four instances share one stimulus:
//   dut0 - defaults (OR encoding, 8-bit counter)
//   dut1 - lowest-set-bit priority encoding
//   dut2 - 2-bit error counter, to reach saturation quickly
//   dut3 - 2-bit index on a 16-bit word, to show index truncation
// ----------------------------------------------------------------------------
module tb_onehot_to_bin_stream;

    logic        clk;
    logic        rst_n;
    logic        valid_in;
    logic [15:0] onehot;
    logic        ready_in;
    logic        clr;

    logic       ready0, valid0, zero0, multi0;
    logic [3:0] bin0;
    logic [7:0] err0;

    logic       ready1, valid1, zero1, multi1;
    logic [3:0] bin1;
    logic [7:0] err1;

    logic       ready2, valid2, zero2, multi2;
    logic [3:0] bin2;
    logic [1:0] err2;

    logic       ready3, valid3, zero3, multi3;
    logic [1:0] bin3;
    logic [7:0] err3;

    int checks_total;
    int checks_passed;

    onehot_to_bin_stream #(.PRIO_MODE(0)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_in), .ready_o(ready0),
        .onehot_i(onehot), .valid_o(valid0), .ready_i(ready_in), .bin_o(bin0),
        .zero_o(zero0), .multi_o(multi0), .clr_i(clr), .err_cnt_o(err0)
    );

    onehot_to_bin_stream #(.PRIO_MODE(1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_in), .ready_o(ready1),
        .onehot_i(onehot), .valid_o(valid1), .ready_i(ready_in), .bin_o(bin1),
        .zero_o(zero1), .multi_o(multi1), .clr_i(clr), .err_cnt_o(err1)
    );

    onehot_to_bin_stream #(.CNT_WIDTH(2)) dut2 (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_in), .ready_o(ready2),
        .onehot_i(onehot), .valid_o(valid2), .ready_i(ready_in), .bin_o(bin2),
        .zero_o(zero2), .multi_o(multi2), .clr_i(clr), .err_cnt_o(err2)
    );

    onehot_to_bin_stream #(.BIN_WIDTH(2)) dut3 (
        .clk_i(clk), .rst_ni(rst_n), .valid_i(valid_in), .ready_o(ready3),
        .onehot_i(onehot), .valid_o(valid3), .ready_i(ready_in), .bin_o(bin3),
        .zero_o(zero3), .multi_o(multi3), .clr_i(clr), .err_cnt_o(err3)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count every comparison. Report any mismatch with both values.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks_total++;
        if (observed === expected) begin
            checks_passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drive one set of inputs. Called just after a clock edge so the inputs
    // are stable well before the next rising edge.
    task automatic applyStimulus(input logic v, input logic [15:0] oh,
                                 input logic rdy, input logic c);
        valid_in = v;
        onehot   = oh;
        ready_in = rdy;
        clr      = c;
    endtask

    // Advance one clock and settle a little past the edge before sampling.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        rst_n = 1'b1;
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);

        // Reset asserted before any clock edge; outputs must clear at once.
        #1 rst_n = 1'b0;
        #1;
        checkOutput("reset_valid", 32'(valid0), 32'd0);
        checkOutput("reset_bin",   32'(bin0),   32'd0);
        checkOutput("reset_zero",  32'(zero0),  32'd0);
        checkOutput("reset_multi", 32'(multi0), 32'd0);
        checkOutput("reset_err",   32'(err0),   32'd0);
        checkOutput("reset_ready", 32'(ready0), 32'd1);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Single legal word, one-cycle latency.
        applyStimulus(1'b1, 16'h0020, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
        checkOutput("single_valid", 32'(valid0), 32'd1);
        checkOutput("single_bin",   32'(bin0),   32'd5);
        checkOutput("single_zero",  32'(zero0),  32'd0);
        checkOutput("single_multi", 32'(multi0), 32'd0);
        checkOutput("single_err",   32'(err0),   32'd0);
        checkOutput("single_prio_bin", 32'(bin1), 32'd5);
        checkOutput("trunc_bin",    32'(bin3),   32'd1);
        tick();
        checkOutput("drain_valid", 32'(valid0), 32'd0);

        // Stall: result must hold while ready_i is low. Input changes ignored.
        applyStimulus(1'b1, 16'h0100, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 16'hFFFF, 1'b0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            checkOutput("stall_valid", 32'(valid0), 32'd1);
            checkOutput("stall_bin",   32'(bin0),   32'd8);
            checkOutput("stall_ready", 32'(ready0), 32'd0);
            tick();
        end
        checkOutput("stall_trunc_bin", 32'(bin3), 32'd0);
        applyStimulus(1'b0, 16'hFFFF, 1'b1, 1'b0);
        #1;
        checkOutput("unstall_ready", 32'(ready0), 32'd1);
        tick();
        checkOutput("unstall_valid", 32'(valid0), 32'd0);
        checkOutput("ignored_err",   32'(err0),   32'd0);

        // Two bits set: OR vs priority encoding, multi flag, counter bump.
        applyStimulus(1'b1, 16'h0006, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
        checkOutput("multi_or_bin",    32'(bin0),   32'd3);
        checkOutput("multi_or_flag",   32'(multi0), 32'd1);
        checkOutput("multi_or_zero",   32'(zero0),  32'd0);
        checkOutput("multi_err",       32'(err0),   32'd1);
        checkOutput("multi_prio_bin",  32'(bin1),   32'd1);
        checkOutput("multi_prio_flag", 32'(multi1), 32'd1);
        checkOutput("multi_trunc_bin", 32'(bin3),   32'd3);
        tick();

        // Zero word.
        applyStimulus(1'b1, 16'h0000, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
        checkOutput("zero_bin",      32'(bin0),   32'd0);
        checkOutput("zero_flag",     32'(zero0),  32'd1);
        checkOutput("zero_multi",    32'(multi0), 32'd0);
        checkOutput("zero_err",      32'(err0),   32'd2);
        checkOutput("zero_prio_bin", 32'(bin1),   32'd0);
        checkOutput("zero_prio_flag", 32'(zero1), 32'd1);
        checkOutput("zero_err_small", 32'(err2),  32'd2);
        tick();

        // Three more illegal words back to back; the small counter saturates.
        applyStimulus(1'b1, 16'h0003, 1'b1, 1'b0);
        tick();
        checkOutput("b2b_or_bin",   32'(bin0), 32'd1);
        checkOutput("b2b_prio_bin", 32'(bin1), 32'd0);
        applyStimulus(1'b1, 16'h0000, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b1, 16'hFFFF, 1'b1, 1'b0);
        tick();
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
        checkOutput("all_or_bin",   32'(bin0),   32'd15);
        checkOutput("all_prio_bin", 32'(bin1),   32'd0);
        checkOutput("all_multi",    32'(multi0), 32'd1);
        checkOutput("err_count5",   32'(err0),   32'd5);
        checkOutput("err_saturate", 32'(err2),   32'd3);
        tick();

        // Clear together with an illegal handshake: clear wins.
        applyStimulus(1'b1, 16'h0000, 1'b1, 1'b1);
        tick();
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
        checkOutput("clr_err",       32'(err0), 32'd0);
        checkOutput("clr_err_small", 32'(err2), 32'd0);
        tick();

        // Back-to-back stream of one-hot words with no bubbles.
        for (int k = 0; k < 16; k++) begin
            applyStimulus(1'b1, 16'(1 << k), 1'b1, 1'b0);
            tick();
            checkOutput("stream_valid",    32'(valid0), 32'd1);
            checkOutput("stream_bin",      32'(bin0),   32'(k));
            checkOutput("stream_prio_bin", 32'(bin1),   32'(k));
        end
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
        tick();
        checkOutput("stream_end_valid", 32'(valid0), 32'd0);
        checkOutput("stream_err",       32'(err0),   32'd0);

        // Reset while a result is stalled: dropped, never emitted.
        applyStimulus(1'b1, 16'h0010, 1'b0, 1'b0);
        tick();
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b0);
        checkOutput("pre_rst_valid", 32'(valid0), 32'd1);
        checkOutput("pre_rst_bin",   32'(bin0),   32'd4);
        #1 rst_n = 1'b0;
        #1;
        checkOutput("midrst_valid", 32'(valid0), 32'd0);
        checkOutput("midrst_bin",   32'(bin0),   32'd0);
        checkOutput("midrst_ready", 32'(ready0), 32'd1);
        tick();
        rst_n = 1'b1;
        applyStimulus(1'b0, 16'h0000, 1'b1, 1'b0);
        tick();
        checkOutput("post_rst_valid", 32'(valid0), 32'd0);
        tick();
        checkOutput("post_rst_valid2", 32'(valid0), 32'd0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
